btn_event_gen: RTL and testbench
================================

# btn_event_gen

Four-channel push-button front end, the stage directly upstream of the per-digit up-counters in the hex display test designs. It takes the raw active-low board buttons, synchronises and debounces them, and emits single-cycle press pulses. Optional typematic auto-repeat produces further pulses while a button is held. The counters then advance exactly once per pulse on the system clock instead of being clocked by debounced button levels.

## Interface
Parameters:
- N_BTN, 4, number of button channels.
- DB_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be ≥1.
- REPEAT_DELAY, 25_000_000, cycles from the first press pulse to the first repeat pulse; must be ≥1.
- REPEAT_RATE, 5_000_000, cycles between successive repeat pulses; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- btn  in  N_BTN  raw button inputs, active-low (0 = pressed), asynchronous to clk.
- rpt_en  in  N_BTN  per-channel auto-repeat enable, active-high, synchronous.
- btn_level  out  N_BTN  debounced state, active-high (1 = pressed).
- btn_press  out  N_BTN  one-cycle pulse on an accepted press and on each repeat.
- btn_release  out  N_BTN  one-cycle pulse on an accepted release.

## Operation
- The channels are fully independent. There is no shared state and no priority between them.
- Synchroniser: two flops per channel, holding the inverted (active-high) input.
- Debounce: a per-channel counter, wide enough to hold DB_CYCLES.
  - Each cycle the synchronised sample differs from btn_level, the counter increments.
  - Each cycle they are equal, the counter clears to 0.
  - When a mismatch has lasted DB_CYCLES consecutive cycles, btn_level toggles and the counter clears.
- btn_press/btn_release: registered and asserted in the same cycle btn_level rises or falls. Each is high for exactly one cycle.
- Repeat FSM per channel, with its counter wide enough for max(REPEAT_DELAY, REPEAT_RATE):
  - IDLE: wait for btn_level to rise. On the rise, emit the press pulse, load the counter, and go to DELAY.
  - DELAY: count REPEAT_DELAY cycles. At expiry:
    - if rpt_en=1, emit a press pulse, reload with REPEAT_RATE, and go to REPEAT;
    - if rpt_en=0, go to HOLD.
  - REPEAT: each REPEAT_RATE expiry emits a press pulse. If rpt_en=0 is sampled, go to HOLD with no pulse that cycle.
  - HOLD: no pulses; wait for the release.
  - From any state, a btn_level fall goes to IDLE. A pending repeat is suppressed in the same cycle the release pulse fires.
- rpt_en changes take effect on the next edge. Setting rpt_en=1 while in HOLD does not restart repeating; a new press is required.
- btn_press and btn_release are never both high on one channel in the same cycle.

## Timing
- Reset (reset=0 at an edge) forces the following to their idle values:
  - btn_level=0, btn_press=0, btn_release=0;
  - synchronisers = not pressed;
  - counters=0;
  - FSM=IDLE.
- Press latency: btn sampled low at edge t and held stable means btn_level=1 and btn_press=1 after edge t+DB_CYCLES+1. Release latency is symmetric.
- Bounce rejection: a glitch shorter than DB_CYCLES cycles produces no output change.
- First press pulse at edge P means repeat pulses at P+REPEAT_DELAY, then P+REPEAT_DELAY+k·REPEAT_RATE for k≥1, while held and rpt_en=1.
- A button held through reset is treated as a new press. It is re-debounced from the first edge with reset=1 and yields a fresh btn_press.
- Reset mid-operation (DELAY/REPEAT) aborts immediately. No pulse is emitted in the reset cycle.
- The outputs are direct flop outputs, with no combinational path from the inputs.

## Test plan
Use DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, with the edges sampling btn numbered from 0.
- Clean press: btn[0] goes 0 at edge 0 and is held 8 cycles, then goes 1. Required response:
  - btn_level[0]=1 and btn_press[0] pulse after edge 5;
  - btn_release[0] pulse 5 cycles after btn returns to 1;
  - all other bits stay 0.
- Bounce: btn[1] toggles every 2 cycles for 20 cycles, then holds 0 from edge H. Required response: no output activity during the toggling; btn_press[1] and btn_level[1]=1 after edge H+5.
- Auto-repeat: rpt_en[2]=1, btn[2] held. Required response:
  - press pulses at P, P+10, P+13, P+16…;
  - on release, one btn_release[2] and no further press pulses.
- Repeat disabled: rpt_en[3]=0, btn[3] held 40 cycles. Required response: exactly one btn_press[3]. Then set rpt_en[3]=1 mid-hold; still no extra pulses.
- Reset mid-repeat: reset=0 at edge r while channel 2 is in REPEAT, with btn still held. Required response:
  - all outputs 0 after edge r;
  - a new btn_press[2] after edge r+6;
  - repeat timing restarts from that edge.
- Simultaneous: all four btn go low at the same edge. Required response: all four btn_press bits pulse in the same cycle, with identical level timing on every channel.

Source files
------------

// File: rtl/btn_event_gen.sv
// Push-button front end: per-channel 2-flop synchroniser, debounce, and press/release
// pulse generation with optional typematic auto-repeat.
module btn_event_gen #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned DB_CYCLES    = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_BTN-1:0] rpt_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int unsigned DW      = $clog2(DB_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_HOLD
  } rpt_state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    rpt_state_e    state_q, state_d;
    logic          rise, fall;

    // Synchroniser and debounce; the level only moves after DB_CYCLES consecutive mismatches.
    always_comb begin
      sync1_d  = ~btn[i];
      sync2_d  = sync1_q;
      level_d  = level_q;
      db_cnt_d = '0;
      if (sync2_q != level_q) begin
        if (db_cnt_q == DW'(DB_CYCLES - 1)) begin
          level_d = ~level_q;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      rise = level_d & ~level_q;
      fall = ~level_d & level_q;
    end

    // Repeat FSM; a fall wins over any repeat expiring in the same cycle.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      press_d   = 1'b0;
      release_d = fall;
      if (fall) begin
        state_d   = S_IDLE;
        rpt_cnt_d = '0;
      end else if (rise) begin
        press_d   = 1'b1;
        rpt_cnt_d = RW'(REPEAT_DELAY - 1);
        state_d   = S_DELAY;
      end else begin
        case (state_q)
          S_DELAY: begin
            if (rpt_cnt_q == '0) begin
              if (rpt_en[i]) begin
                press_d   = 1'b1;
                rpt_cnt_d = RW'(REPEAT_RATE - 1);
                state_d   = S_REPEAT;
              end else begin
                state_d = S_HOLD;
              end
            end else begin
              rpt_cnt_d = rpt_cnt_q - RW'(1);
            end
          end
          S_REPEAT: begin
            if (!rpt_en[i]) begin
              state_d = S_HOLD;
            end else if (rpt_cnt_q == '0) begin
              press_d   = 1'b1;
              rpt_cnt_d = RW'(REPEAT_RATE - 1);
            end else begin
              rpt_cnt_d = rpt_cnt_q - RW'(1);
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        db_cnt_q  <= '0;
        rpt_cnt_q <= '0;
        state_q   <= S_IDLE;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        db_cnt_q  <= db_cnt_d;
        rpt_cnt_q <= rpt_cnt_d;
        state_q   <= state_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen: stimulus queues expected pulses (cycle, channel,
// kind); a forked monitor pops and compares on every observed pulse.
module tb_btn_event_gen;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] rpt_en;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  btn_event_gen #(
    .N_BTN(4),
    .DB_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .rpt_en(rpt_en),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  // DB_CYCLES=4: change at negedge c is sampled at edge c+1, level moves after edge c+6
  localparam int LAT = 6;

  typedef struct {
    int cyc;
    int ch;
    bit press;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int at, input int ch, input bit press);
    exp_t e;
    e.cyc = at;
    e.ch = ch;
    e.press = press;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_%s: ch%0d no pulse at cycle %0d (now %0d)",
                 e.press ? "press" : "release", e.ch, e.cyc, cyc);
      end
      for (int ch = 0; ch < 4; ch++) begin
        for (int k = 0; k < 2; k++) begin
          if ((k == 0 && btn_press[ch] === 1'b1) || (k == 1 && btn_release[ch] === 1'b1)) begin
            n_tests++;
            if (sb.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_%s: ch%0d pulse at cycle %0d, none required",
                       (k == 0) ? "press" : "release", ch, cyc);
            end else begin
              e = sb.pop_front();
              if (e.ch != ch || e.press != (k == 0) || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL pulse: got ch%0d %s at cycle %0d, required ch%0d %s at cycle %0d",
                         ch, (k == 0) ? "press" : "release", cyc,
                         e.ch, e.press ? "press" : "release", e.cyc);
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    int now;
    int p;
    reset  = 1'b0;
    btn    = 4'hF;
    rpt_en = 4'h0;
    fork
      monitor();
    join_none
    tick(3);
    check("reset_level", btn_level, 4'h0);
    check("reset_press", btn_press, 4'h0);
    check("reset_release", btn_release, 4'h0);
    reset = 1'b1;
    tick(4);

    // clean press on ch0, held 8 cycles
    now = cyc;
    btn[0] = 1'b0;
    expect_ev(now + LAT, 0, 1'b1);
    tick(7);
    check("clean_level_hi", btn_level, 4'b0001);
    tick(1);
    btn[0] = 1'b1;
    expect_ev(cyc + LAT, 0, 1'b0);
    tick(10);
    check("clean_level_lo", btn_level, 4'b0000);

    // bounce on ch1: 2-cycle toggles must be rejected
    for (int k = 0; k < 5; k++) begin
      btn[1] = 1'b0;
      tick(2);
      btn[1] = 1'b1;
      tick(2);
    end
    check("bounce_level", btn_level, 4'b0000);
    now = cyc;
    btn[1] = 1'b0;
    expect_ev(now + LAT, 1, 1'b1);
    tick(12);
    check("bounce_settled", btn_level, 4'b0010);
    btn[1] = 1'b1;
    expect_ev(cyc + LAT, 1, 1'b0);
    tick(10);

    // auto-repeat on ch2; release lands where the 5th repeat would have been
    rpt_en[2] = 1'b1;
    now = cyc;
    btn[2] = 1'b0;
    p = now + LAT;
    expect_ev(p, 2, 1'b1);
    expect_ev(p + 10, 2, 1'b1);
    expect_ev(p + 13, 2, 1'b1);
    expect_ev(p + 16, 2, 1'b1);
    expect_ev(p + 19, 2, 1'b1);
    tick(22);
    btn[2] = 1'b1;
    expect_ev(p + 22, 2, 1'b0);
    tick(10);

    // repeat disabled on ch3; enabling it mid-hold must not restart repeats
    rpt_en[3] = 1'b0;
    now = cyc;
    btn[3] = 1'b0;
    expect_ev(now + LAT, 3, 1'b1);
    tick(21);
    rpt_en[3] = 1'b1;
    tick(19);
    btn[3] = 1'b1;
    expect_ev(cyc + LAT, 3, 1'b0);
    tick(10);

    // reset while ch2 is repeating, button held through reset
    rpt_en = 4'b0100;
    now = cyc;
    btn[2] = 1'b0;
    p = now + LAT;
    expect_ev(p, 2, 1'b1);
    expect_ev(p + 10, 2, 1'b1);
    expect_ev(p + 13, 2, 1'b1);
    tick(20);
    reset = 1'b0;
    tick(1);
    check("rst_mid_level", btn_level, 4'h0);
    check("rst_mid_press", btn_press, 4'h0);
    check("rst_mid_release", btn_release, 4'h0);
    reset = 1'b1;
    expect_ev(p + 21, 2, 1'b1);
    expect_ev(p + 31, 2, 1'b1);
    expect_ev(p + 34, 2, 1'b1);
    expect_ev(p + 37, 2, 1'b1);
    expect_ev(p + 40, 2, 1'b1);
    tick(20);
    btn[2] = 1'b1;
    expect_ev(p + 41, 2, 1'b0);
    tick(10);

    // all four channels pressed on the same edge
    rpt_en = 4'h0;
    now = cyc;
    btn = 4'h0;
    for (int ch = 0; ch < 4; ch++) expect_ev(now + LAT, ch, 1'b1);
    tick(7);
    check("simul_level_hi", btn_level, 4'hF);
    tick(3);
    now = cyc;
    btn = 4'hF;
    for (int ch = 0; ch < 4; ch++) expect_ev(now + LAT, ch, 1'b0);
    tick(10);
    check("simul_level_lo", btn_level, 4'h0);

    tick(5);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d pulses still outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
